quad_step_decoder: RTL and testbench

//  Consumes debounced rotary-encoder phases A/B and the push-button. Decodes quadrature

---
 rtl/quad_step_decoder_pkg.sv | 17 +
 rtl/quad_step_decoder_if.sv | 10 +
 rtl/quad_step_decoder_sync_ff.sv | 13 +
 rtl/quad_step_decoder.sv | 86 ++++++++
 tb/tb_quad_step_decoder.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/quad_step_decoder_pkg.sv
// quad_pkg: Gray phase encodings, quadrature delta decode and LED stretch width for quad_step_decoder.
package quad_pkg;
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam int LED_STRETCH_W = 22;
   typedef enum logic [1:0] {D_IDLE, D_CW, D_CCW, D_ILLEGAL} quad_delta_t;
   function automatic logic [1:0] gray_idx(input logic [1:0] ph);
      return {ph[0], ph[1] ^ ph[0]};
   endfunction
   function automatic quad_delta_t quad_delta(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] d;
      d = gray_idx(cur) - gray_idx(prev);
      return d == 2'd0 ? D_IDLE : d == 2'd1 ? D_CW : d == 2'd3 ? D_CCW : D_ILLEGAL;
   endfunction
endpackage

// File: rtl/quad_step_decoder_if.sv
// quad_step_decoder_if: encoder inputs and decoded position/status outputs of quad_step_decoder.
interface quad_step_decoder_if #(parameter int POS_W = 5, parameter int ERR_W = 8);
   logic A, B, BTN;
   logic [POS_W-1:0] pos;
   logic dir, step, err;
   logic [ERR_W-1:0] err_cnt;
   logic [1:0] LED;
   modport master(output A, B, BTN, input pos, dir, step, err, err_cnt, LED);
   modport slave(input A, B, BTN, output pos, dir, step, err, err_cnt, LED);
endinterface

// File: rtl/quad_step_decoder_sync_ff.sv
// sync_ff: multi-stage synchronizer for one asynchronous bit, async active-low reset to 0.
module sync_ff #(parameter int STAGES = 2) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sr;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sr <= '0;
      else sr <= {sr[STAGES-2:0], d};
   assign q = sr[STAGES-1];
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature decode of synchronized A/B into a wrapped detent position
// with direction, step/error pulses, saturating error count, button clear and stretched LED.
module quad_step_decoder import quad_pkg::*; #(
   parameter int POS_MAX          = 19,
   parameter int POS_W            = 5,
   parameter int STEPS_PER_DETENT = 4,
   parameter int SYNC_STAGES      = 2,
   parameter int ERR_W            = 8
) (
   input logic clk,
   input logic reset_n,
   quad_step_decoder_if.slave bus
);
   localparam int SUB_W = $clog2(STEPS_PER_DETENT) + 1;
   localparam int LED_W = LED_STRETCH_W + 1;
   localparam logic signed [SUB_W-1:0] SUB_TOP = SUB_W'(STEPS_PER_DETENT - 1);
   localparam logic signed [SUB_W-1:0] SUB_BOT = -SUB_TOP;
   localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);
   localparam logic [LED_W-1:0] LED_LOAD = LED_W'(1) << LED_STRETCH_W;
   logic s_a, s_b, s_btn, seeded, dir, step, err;
   logic [1:0] cur, prev;
   logic [SYNC_STAGES-1:0] fill;
   logic signed [SUB_W-1:0] sub;
   logic [POS_W-1:0] pos;
   logic [ERR_W-1:0] err_cnt;
   logic [LED_W-1:0] led_cnt;
   quad_delta_t delta;
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a   (.clk(clk), .reset_n(reset_n), .d(bus.A),   .q(s_a));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b   (.clk(clk), .reset_n(reset_n), .d(bus.B),   .q(s_b));
   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_btn (.clk(clk), .reset_n(reset_n), .d(bus.BTN), .q(s_btn));
   assign cur   = {s_a, s_b};
   assign delta = quad_delta(prev, cur);
   // fill mirrors the sync chain refill, so the seed is taken from a real post-reset pin sample
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         fill    <= '0;
         seeded  <= 1'b0;
         prev    <= '0;
         sub     <= '0;
         pos     <= '0;
         dir     <= 1'b0;
         step    <= 1'b0;
         err     <= 1'b0;
         err_cnt <= '0;
         led_cnt <= '0;
      end else begin
         fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
         prev    <= cur;
         step    <= 1'b0;
         err     <= 1'b0;
         led_cnt <= led_cnt != '0 ? led_cnt - LED_W'(1) : led_cnt;
         if (!seeded) seeded <= fill[SYNC_STAGES-1];
         else begin
            if (delta == D_ILLEGAL) begin
               err     <= 1'b1;
               err_cnt <= err_cnt != '1 ? err_cnt + ERR_W'(1) : err_cnt;
            end
            if (s_btn) begin
               pos <= '0;
               sub <= '0;
            end else if (delta == D_CW) begin
               if (sub == SUB_TOP) begin
                  sub     <= '0;
                  pos     <= pos == POS_TOP ? '0 : pos + POS_W'(1);
                  dir     <= 1'b1;
                  step    <= 1'b1;
                  led_cnt <= LED_LOAD;
               end else sub <= sub + SUB_W'(1);
            end else if (delta == D_CCW) begin
               if (sub == SUB_BOT) begin
                  sub     <= '0;
                  pos     <= pos == '0 ? POS_TOP : pos - POS_W'(1);
                  dir     <= 1'b0;
                  step    <= 1'b1;
                  led_cnt <= LED_LOAD;
               end else sub <= sub - SUB_W'(1);
            end
         end
      end
   assign bus.pos     = pos;
   assign bus.dir     = dir;
   assign bus.step    = step;
   assign bus.err     = err;
   assign bus.err_cnt = err_cnt;
   assign bus.LED     = {dir, led_cnt != '0};
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed scenarios plus random rotation checked against a phase-index model.
module tb_quad_step_decoder;
   logic clk = 1'b0, reset_n = 1'b0;
   int n_chk = 0, n_pass = 0, cyc = 0, n_step = 0, n_err = 0, last_step = -1;
   int m_pos, m_sub, m_dir, m_errc, m_steps = 0, m_errs = 0, t_apply = 0;
   int s0, e0;
   logic [1:0] m_ph;
   logic [1:0] gph [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   quad_step_decoder_if bus();
   quad_step_decoder dut(.clk(clk), .reset_n(reset_n), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.step === 1'b1) begin n_step++; last_step = cyc; end
      if (bus.err === 1'b1) n_err++;
   end
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   function automatic int gidx(input logic [1:0] p);
      for (int i = 0; i < 4; i++) if (gph[i] == p) return i;
      return 0;
   endfunction
   task automatic model_reset(input logic [1:0] p);
      m_pos = 0; m_sub = 0; m_dir = 0; m_errc = 0; m_ph = p;
   endtask
   task automatic move(input logic [1:0] p, input logic btn, input int gap);
      int d;
      d = (gidx(p) - gidx(m_ph) + 4) % 4;
      bus.A = p[1]; bus.B = p[0]; bus.BTN = btn; t_apply = cyc;
      if (d == 2) begin m_errs++; if (m_errc < 255) m_errc++; end
      if (btn) begin m_pos = 0; m_sub = 0; end
      else if (d == 1) begin
         m_sub++;
         if (m_sub == 4) begin m_sub = 0; m_pos = (m_pos + 1) % 20; m_dir = 1; m_steps++; end
      end else if (d == 3) begin
         m_sub--;
         if (m_sub == -4) begin m_sub = 0; m_pos = (m_pos + 19) % 20; m_dir = 0; m_steps++; end
      end
      m_ph = p;
      repeat (gap) @(posedge clk);
      #1;
   endtask
   task automatic cw(input int n, input int gap);
      for (int i = 0; i < n; i++) move(gph[(gidx(m_ph) + 1) % 4], 1'b0, gap);
   endtask
   task automatic ccw(input int n, input int gap);
      for (int i = 0; i < n; i++) move(gph[(gidx(m_ph) + 3) % 4], 1'b0, gap);
   endtask
   task automatic do_reset(input logic [1:0] p);
      reset_n = 1'b0; bus.A = p[1]; bus.B = p[0]; bus.BTN = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset(p);
      repeat (6) @(posedge clk);
      #1;
   endtask
   task automatic check_state(input string tag);
      check({tag, "_pos"}, bus.pos, m_pos);
      check({tag, "_dir"}, bus.dir, m_dir);
      check({tag, "_errcnt"}, bus.err_cnt, m_errc);
   endtask
   initial begin
      do_reset(2'b11);
      repeat (4) @(posedge clk);
      #1;
      check("t1_pos", bus.pos, 0);
      check("t1_steps", n_step, 0);
      check("t1_errcnt", bus.err_cnt, 0);
      check("t1_errs", n_err, 0);
      check("t1_led", bus.LED, 0);
      do_reset(2'b00);
      s0 = n_step;
      cw(4, 20);
      check("t2_steps", n_step - s0, 1);
      check("t2_latency", last_step - t_apply, 3);
      check("t2_pos", bus.pos, 1);
      check("t2_dir", bus.dir, 1);
      check("t2_led", bus.LED, 3);
      move(m_ph, 1'b1, 4);
      move(m_ph, 1'b0, 4);
      check("t3_clear_pos", bus.pos, 0);
      ccw(4, 4);
      check("t3_ccw_pos", bus.pos, 19);
      check("t3_ccw_dir", bus.dir, 0);
      check("t3_led1", bus.LED[1], 0);
      s0 = n_step;
      cw(84, 4);
      check("t3_wrap_pos", bus.pos, 0);
      check("t3_wrap_steps", n_step - s0, 21);
      e0 = n_err;
      move(2'b11, 1'b0, 4);
      check("t4_err_pulse", n_err - e0, 1);
      check("t4_errcnt", bus.err_cnt, 1);
      check("t4_pos", bus.pos, 0);
      for (int i = 0; i < 300; i++) move(m_ph ^ 2'b11, 1'b0, 3);
      repeat (2) @(posedge clk);
      #1;
      check("t4_sat", bus.err_cnt, 255);
      check("t4_pulses", n_err, m_errs);
      move(m_ph, 1'b1, 4);
      cw(31, 4);
      check("t5_pos7", bus.pos, 7);
      s0 = n_step;
      move(gph[(gidx(m_ph) + 1) % 4], 1'b1, 4);
      check("t5_clear_pos", bus.pos, 0);
      check("t5_no_step", n_step - s0, 0);
      cw(4, 4);
      check("t5_next_pos", bus.pos, 1);
      cw(2, 4);
      check("t6_pre_pos", bus.pos, 1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("t6_async_pos", bus.pos, 0);
      check("t6_async_errcnt", bus.err_cnt, 0);
      check("t6_async_led", bus.LED, 0);
      check("t6_async_step", bus.step, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset(m_ph);
      repeat (6) @(posedge clk);
      #1;
      check_state("t6_seed");
      cw(4, 4);
      check("t6_pos", bus.pos, 1);
      for (int i = 0; i < 250; i++) begin
         int r;
         logic [1:0] p;
         r = $urandom_range(0, 9);
         p = r < 5 ? gph[(gidx(m_ph) + 1) % 4] : r < 8 ? gph[(gidx(m_ph) + 3) % 4] :
             r == 8 ? gph[(gidx(m_ph) + 2) % 4] : m_ph;
         move(p, $urandom_range(0, 15) == 0, $urandom_range(4, 8));
         check_state("rnd");
      end
      check("rnd_steps", n_step, m_steps);
      check("rnd_errs", n_err, m_errs);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
